lfu_victim_select: RTL and testbench
====================================

# lfu_victim_select

Least-frequently-used victim selector for the set-associative cache controller. On a miss it reads every way's usage count for one set from the LFU counter array over that array's `address`/`count_read`/`count_out` read port. It then reports the way with the smallest count as the replacement victim. It is the consumer (reader) side of the counter array's read interface; the replacement controller uses the result to refill and to pulse `line_reset` on the chosen line.

## Interface
- `bitsDirect`, default 10: counter-array address width (total cache lines = 2**bitsDirect).
- `sizeCounter`, default 4: width of one usage counter.
- `bitsWays`, default 2: log2 of ways per set; numWays = 2**bitsWays; set-index width = bitsDirect-bitsWays.
- `clk`  input  1: single clock, all state on rising edge.
- `gen_reset`  input  1: reset, asynchronous, active-high.
- `start`  input  1: request a victim search; sampled only in IDLE.
- `set_index`  input  bitsDirect-bitsWays: set to search; captured on the accepted `start`.
- `cnt_address`  output  bitsDirect: counter-array address = {captured set, way index}.
- `cnt_read`  output  1: counter-array read strobe.
- `cnt_in`  input  sizeCounter: counter-array `count_out`; valid only the cycle after `cnt_read`=1; high-Z otherwise, ignored then.
- `busy`  output  1: high from the cycle after an accepted `start` through the DONE cycle.
- `done`  output  1: one-cycle pulse; victim outputs valid.
- `victim_way`  output  bitsWays: selected way.
- `victim_count`  output  sizeCounter: count of the selected way.

## Operation
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - `start`=1 captures `set_index`, clears way index to 0, and moves to SCAN.
  - `start` is ignored in every other state; it is not queued.
- SCAN:
  - `cnt_read`=1 and `cnt_address`={set, way index}.
  - Way index increments each cycle.
  - After issuing way numWays-1, move to DRAIN.
- DRAIN: `cnt_read`=0; consumes the last outstanding count; then DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Compare, in the cycle after each issued read:
  - The first returned count (way 0) unconditionally loads `victim_way`/`victim_count`.
  - Each later count replaces them only if it is strictly less than `victim_count`.
  - On a tie, the lowest way index wins.
- `cnt_address` and `cnt_read` are Moore outputs: decoded from the state register and way index, with no combinational path from `start` or `cnt_in`.
- Counts are unsigned and sizeCounter wide; a saturated or wrapped value in the counter array is compared as-is.
- `victim_way`/`victim_count` hold their last value after DONE until the next search loads way 0.
- Reset (any state, including mid-SCAN) forces IDLE immediately:
  - `busy`, `done`, `cnt_read`, `cnt_address`, `victim_way` and `victim_count` all go to 0.
  - Any in-flight read result is discarded.

## Timing
- Accepted `start` at edge 0; SCAN occupies cycles 1..numWays.
- Way k is issued in cycle k+1; its count is on `cnt_in` and compared in cycle k+2.
- DRAIN is cycle numWays+1; `done` is high in cycle numWays+2.
- The earliest next accepted `start` is sampled in cycle numWays+3 (back in IDLE).
- For the default numWays=4: `done` arrives 6 cycles after `start`, and a new search can be accepted every 7 cycles.
- Reset values: all outputs 0; state IDLE.

## Configuration
- `LFU_SKIP_ZERO_EN`: early termination.
  - **Defined:** when a compared count equals 0, the block loads it as victim (subject to the lowest-index tie rule) and goes directly to DONE on the next edge. Remaining SCAN issues and DRAIN are skipped, and the one read already in flight is discarded. A zero seen on way k gives `done` in cycle k+3.
  - **Undefined:** always the full numWays scan; zero counts get no special handling.
  - Victim selection results are identical in both builds.

## Test plan
- Reset: assert `gen_reset` asynchronously mid-cycle -> every output reads 0 before the next clock edge; FSM in IDLE.
- Counts for set 0x12 of {5,3,7,3}, `start` at cycle 0 -> `cnt_address` = 0x048,0x049,0x04A,0x04B in cycles 1-4, `cnt_read`=1 only in those cycles; `done` pulses in cycle 6 with `victim_way`=1, `victim_count`=3.
- Counts {15,15,15,15} -> `victim_way`=0, `victim_count`=15 (tie picks the lowest way).
- `start` held high for 10 cycles -> exactly one search per IDLE visit: `done` in cycles 6 and 13; no start is accepted while `busy`=1.
- `gen_reset` pulsed in cycle 3 of a search -> outputs 0, no `done`; a new `start` after release completes normally with the correct victim.
- Counts {4,0,2,1}:
  - With `LFU_SKIP_ZERO_EN` defined: `done` in cycle 4, `victim_way`=1, `victim_count`=0, `cnt_read` low from cycle 4.
  - Without the macro: `done` in cycle 6 with the same result.

Source files
------------

// File: rtl/lfu_victim_select.sv
// lfu_victim_select: least-frequently-used victim search over one cache set.
// Reads every way's usage count from the LFU counter array and reports the
// way with the smallest count; ties go to the lowest way index.
// Optional build macro: LFU_SKIP_ZERO_EN (stop the scan early on a zero count).
module lfu_victim_select #(
  parameter int bitsDirect  = 10,
  parameter int sizeCounter = 4,
  parameter int bitsWays    = 2
) (
  input  logic                             clk,
  input  logic                             gen_reset,
  input  logic                             start,
  input  logic [bitsDirect-bitsWays-1:0]   set_index,
  output logic [bitsDirect-1:0]            cnt_address,
  output logic                             cnt_read,
  input  logic [sizeCounter-1:0]           cnt_in,
  output logic                             busy,
  output logic                             done,
  output logic [bitsWays-1:0]              victim_way,
  output logic [sizeCounter-1:0]           victim_count
);

  localparam int SetW = bitsDirect - bitsWays;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SetW-1:0]        set_q, set_d;
  logic [bitsWays-1:0]    way_q, way_d;
  // A read issued last cycle whose count is on cnt_in now, and its way.
  logic                   pend_q, pend_d;
  logic [bitsWays-1:0]    pend_way_q, pend_way_d;
  logic [bitsWays-1:0]    vway_q, vway_d;
  logic [sizeCounter-1:0] vcnt_q, vcnt_d;

  logic take;
  logic zero_hit;

  // Compare the returned count: way 0 loads unconditionally, later ways only if strictly smaller.
  always_comb begin
    take     = pend_q && ((pend_way_q == '0) || (cnt_in < vcnt_q));
    zero_hit = pend_q && (cnt_in == '0);
  end

  // Next-state, capture and victim-update logic.
  always_comb begin
    state_d    = state_q;
    set_d      = set_q;
    way_d      = way_q;
    pend_d     = 1'b0;
    pend_way_d = pend_way_q;
    vway_d     = vway_q;
    vcnt_d     = vcnt_q;

    if (take) begin
      vway_d = pend_way_q;
      vcnt_d = cnt_in;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          set_d   = set_index;
          way_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        pend_d     = 1'b1;
        pend_way_d = way_q;
        way_d      = way_q + 1'b1;
        if (way_q == '1) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef LFU_SKIP_ZERO_EN
    // Nothing can beat a zero: finish now and drop the read still in flight.
    if (zero_hit) begin
      state_d = DONE;
      pend_d  = 1'b0;
    end
`else
    if (zero_hit) begin
      state_d = state_d;
    end
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) begin
      state_q    <= IDLE;
      set_q      <= '0;
      way_q      <= '0;
      pend_q     <= 1'b0;
      pend_way_q <= '0;
      vway_q     <= '0;
      vcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      set_q      <= set_d;
      way_q      <= way_d;
      pend_q     <= pend_d;
      pend_way_q <= pend_way_d;
      vway_q     <= vway_d;
      vcnt_q     <= vcnt_d;
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    cnt_read     = (state_q == SCAN);
    cnt_address  = cnt_read ? {set_q, way_q} : '0;
    busy         = (state_q != IDLE);
    done         = (state_q == DONE);
    victim_way   = vway_q;
    victim_count = vcnt_q;
  end

endmodule

// File: tb/tb_lfu_victim_select.sv
// Self-checking bench for lfu_victim_select with a behavioural counter-array
// model and an argmin reference computed directly from the per-way counts.
module tb_lfu_victim_select;

  localparam int BD = 10;
  localparam int SC = 4;
  localparam int BW = 2;
  localparam int NW = 1 << BW;
  localparam int SW = BD - BW;

  logic          clk = 1'b0;
  logic          gen_reset;
  logic          start;
  logic [SW-1:0] set_index;
  logic [BD-1:0] cnt_address;
  logic          cnt_read;
  logic [SC-1:0] cnt_in;
  logic          busy;
  logic          done;
  logic [BW-1:0] victim_way;
  logic [SC-1:0] victim_count;

  int checks   = 0;
  int failures = 0;

  logic [SC-1:0] mem [0:(1<<BD)-1];
  int unsigned   cnt_tab [NW];

  lfu_victim_select #(.bitsDirect(BD), .sizeCounter(SC), .bitsWays(BW)) dut (
    .clk(clk), .gen_reset(gen_reset), .start(start), .set_index(set_index),
    .cnt_address(cnt_address), .cnt_read(cnt_read), .cnt_in(cnt_in),
    .busy(busy), .done(done), .victim_way(victim_way), .victim_count(victim_count)
  );

  always #5 clk = ~clk;

  // Counter array: data one cycle after a read, garbage otherwise.
  always @(posedge clk) begin
    if (cnt_read) cnt_in <= mem[cnt_address];
    else          cnt_in <= SC'($urandom);
  end

  // Reference: lowest-index minimum, and the cycle done is expected in.
  task automatic model(output int ew, output int ec, output int ed);
    ew = 0;
    ec = int'(cnt_tab[0]);
    for (int w = 1; w < NW; w++) begin
      if (int'(cnt_tab[w]) < ec) begin
        ew = w;
        ec = int'(cnt_tab[w]);
      end
    end
    ed = NW + 2;
`ifdef LFU_SKIP_ZERO_EN
    for (int w = NW - 1; w >= 0; w--) begin
      if (cnt_tab[w] == 0) ed = w + 3;
    end
`endif
  endtask

  task automatic run_search(input logic [SW-1:0] s, input string tag);
    int ew, ec, ed;
    logic exp_read;
    logic [BD-1:0] exp_addr;
    model(ew, ec, ed);
    for (int w = 0; w < NW; w++) mem[{s, BW'(w)}] = SC'(cnt_tab[w]);
    @(negedge clk);
    start = 1'b1;
    set_index = s;
    for (int n = 1; n <= ed + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        set_index = SW'($urandom);
      end
      exp_read = (n <= NW) && (n <= ed - 1);
      exp_addr = {s, BW'(n - 1)};
      checks++;
      if (cnt_read !== exp_read) begin
        failures++;
        $display("FAIL %s cnt_read cycle %0d: got %b expected %b", tag, n, cnt_read, exp_read);
      end
      if (exp_read) begin
        checks++;
        if (cnt_address !== exp_addr) begin
          failures++;
          $display("FAIL %s cnt_address cycle %0d: got %h expected %h", tag, n, cnt_address, exp_addr);
        end
      end
      checks++;
      if (done !== (n == ed)) begin
        failures++;
        $display("FAIL %s done cycle %0d: got %b expected %b", tag, n, done, n == ed);
      end
      checks++;
      if (busy !== (n <= ed)) begin
        failures++;
        $display("FAIL %s busy cycle %0d: got %b expected %b", tag, n, busy, n <= ed);
      end
      if (n >= ed) begin
        checks++;
        if (victim_way !== BW'(ew) || victim_count !== SC'(ec)) begin
          failures++;
          $display("FAIL %s victim cycle %0d: got way %0d count %0d expected way %0d count %0d",
                   tag, n, victim_way, victim_count, ew, ec);
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cnt_read !== 1'b0 || cnt_address !== '0 ||
        victim_way !== '0 || victim_count !== '0) begin
      failures++;
      $display("FAIL %s outputs: got busy %b done %b read %b addr %h way %0d count %0d expected all 0",
               tag, busy, done, cnt_read, cnt_address, victim_way, victim_count);
    end
  endtask

  task automatic test_reset;
    gen_reset = 1'b1;
    start = 1'b0;
    set_index = '0;
    #1;
    check_all_zero("reset_initial");
    repeat (2) @(negedge clk);
    gen_reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset_released");
  endtask

  task automatic test_directed;
    cnt_tab = '{5, 3, 7, 3};
    run_search(SW'(8'h12), "directed_5373");
  endtask

  task automatic test_tie;
    cnt_tab = '{15, 15, 15, 15};
    run_search(SW'(8'h33), "tie_all15");
    cnt_tab = '{9, 2, 2, 2};
    run_search(SW'(8'hA0), "tie_later");
  endtask

  task automatic test_zero;
    cnt_tab = '{4, 0, 2, 1};
    run_search(SW'(8'h05), "zero_way1");
    cnt_tab = '{0, 0, 3, 6};
    run_search(SW'(8'h06), "zero_way0");
    cnt_tab = '{7, 8, 9, 0};
    run_search(SW'(8'h07), "zero_way3");
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      for (int w = 0; w < NW; w++)
        cnt_tab[w] = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, (1 << SC) - 1);
      run_search(SW'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back;
    int ed_full;
    int exp_dones [$];
    int nxt;
    int got_dones;
    cnt_tab = '{6, 9, 4, 11};
    for (int w = 0; w < NW; w++) mem[{SW'(8'h44), BW'(w)}] = SC'(cnt_tab[w]);
    ed_full = NW + 2;
    nxt = 0;
    while (nxt < 10) begin
      exp_dones.push_back(nxt + ed_full);
      nxt = nxt + ed_full + 1;
    end
    got_dones = 0;
    @(negedge clk);
    start = 1'b1;
    set_index = SW'(8'h44);
    for (int n = 1; n <= 2 * ed_full + 6; n++) begin
      @(negedge clk);
      if (n == 10) start = 1'b0;
      checks++;
      if (done !== ((n == exp_dones[0]) || (n == exp_dones[1]))) begin
        failures++;
        $display("FAIL b2b done cycle %0d: got %b expected %b", n, done,
                 (n == exp_dones[0]) || (n == exp_dones[1]));
      end
      if (done) begin
        got_dones++;
        checks++;
        if (victim_way !== BW'(2) || victim_count !== SC'(4)) begin
          failures++;
          $display("FAIL b2b victim: got way %0d count %0d expected way 2 count 4", victim_way, victim_count);
        end
      end
    end
    checks++;
    if (got_dones != exp_dones.size()) begin
      failures++;
      $display("FAIL b2b done_count: got %0d expected %0d", got_dones, exp_dones.size());
    end
  endtask

  task automatic test_reset_mid;
    int saw_done;
    cnt_tab = '{8, 6, 7, 5};
    for (int w = 0; w < NW; w++) mem[{SW'(8'h21), BW'(w)}] = SC'(cnt_tab[w]);
    @(negedge clk);
    start = 1'b1;
    set_index = SW'(8'h21);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    gen_reset = 1'b1;
    #1;
    check_all_zero("reset_mid_async");
    @(negedge clk);
    gen_reset = 1'b0;
    saw_done = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    checks++;
    if (saw_done != 0) begin
      failures++;
      $display("FAIL reset_mid no_done: got %0d done pulses expected 0", saw_done);
    end
    check_all_zero("reset_mid_idle");
    cnt_tab = '{3, 12, 1, 9};
    run_search(SW'(8'h21), "after_reset");
  endtask

  initial begin
    cnt_in = '0;
    for (int a = 0; a < (1 << BD); a++) mem[a] = SC'($urandom);
    test_reset;
    test_directed;
    test_tie;
    test_zero;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
